// File: rtl/dlx_fetch_if.sv
// Fetch-stage bus bundle: ROM port, redirect/halt controls and the decode handshake.
// The master modport is the fetch stage; slave is its environment (ROM, decode, execute).
interface dlx_fetch_if #(
    parameter int unsigned DEPTH = 4
);
    logic [31:0]             i_address;
    logic [31:0]             i_data_read;
    logic                    i_data_valid;
    logic                    redirect_valid;
    logic [31:0]             redirect_pc;
    logic                    halt;
    logic                    inst_valid;
    logic                    inst_ready;
    logic [31:0]             inst_word;
    logic [31:0]             inst_pc;
    logic [$clog2(DEPTH):0]  fifo_count;

    modport master (
        output i_address, inst_valid, inst_word, inst_pc, fifo_count,
        input  i_data_read, i_data_valid, redirect_valid, redirect_pc, halt, inst_ready
    );

    modport slave (
        input  i_address, inst_valid, inst_word, inst_pc, fifo_count,
        output i_data_read, i_data_valid, redirect_valid, redirect_pc, halt, inst_ready
    );
endinterface

// File: rtl/dlx_fetch.sv
// DLX instruction fetch: owns the fetch PC, captures ROM words into a PC-tagged prefetch FIFO.
// Optional fetch/stall counters are enabled by defining DLX_FETCH_STATS_EN.
module dlx_fetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset_n,
    dlx_fetch_if.master   bus
`ifdef DLX_FETCH_STATS_EN
    ,
    output logic [31:0]   stat_fetched,
    output logic [31:0]   stat_stall
`endif
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] StBoot   = 2'd0;
    localparam logic [1:0] StFetch  = 2'd1;
    localparam logic [1:0] StHold   = 2'd2;
    localparam logic [1:0] StHalted = 2'd3;

    logic [1:0]    r_state;
    logic [31:0]   r_pc;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [31:0]   r_mem_word [DEPTH];
    logic [31:0]   r_mem_pc   [DEPTH];

    logic          w_full;
    logic          w_capture;
    logic          w_pop;
    logic          w_valid;
    logic [CW-1:0] w_count_d;
    logic [1:0]    w_state_d;
    logic [31:0]   w_pc_d;

    // Fullness is judged on the registered count, so a same-cycle pop cannot unblock a push.
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_valid   = (r_count != '0);
    assign w_capture = bus.i_data_valid && (r_state == StFetch) && !w_full
                       && !bus.redirect_valid;
    assign w_pop     = w_valid && bus.inst_ready && !bus.redirect_valid;

    always_comb begin
        w_count_d = r_count;
        if (bus.redirect_valid) begin
            w_count_d = '0;
        end else if (w_capture && !w_pop) begin
            w_count_d = r_count + CW'(1);
        end else if (!w_capture && w_pop) begin
            w_count_d = r_count - CW'(1);
        end
    end

    always_comb begin
        w_pc_d = r_pc;
        if (bus.redirect_valid) begin
            w_pc_d = {bus.redirect_pc[31:2], 2'b00};
        end else if (w_capture) begin
            w_pc_d = r_pc + 32'd4;
        end
    end

    always_comb begin
        w_state_d = r_state;
        if (bus.redirect_valid) begin
            w_state_d = bus.halt ? StHalted : StFetch;
        end else begin
            unique case (r_state)
                StBoot:   w_state_d = StFetch;
                StFetch: begin
                    if (bus.halt) begin
                        w_state_d = StHalted;
                    end else if (w_count_d == CW'(DEPTH)) begin
                        w_state_d = StHold;
                    end
                end
                StHold:   if (r_count < CW'(DEPTH)) w_state_d = StFetch;
                StHalted: if (!bus.halt) w_state_d = StFetch;
                default:  w_state_d = StBoot;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= StBoot;
            r_pc     <= RESET_PC;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_state <= w_state_d;
            r_pc    <= w_pc_d;
            r_count <= w_count_d;
            if (bus.redirect_valid) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_capture) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem_word[i] <= '0;
                r_mem_pc[i]   <= '0;
            end
        end else if (w_capture) begin
            r_mem_word[r_wr_ptr] <= bus.i_data_read;
            r_mem_pc[r_wr_ptr]   <= r_pc;
        end
    end

    assign bus.i_address  = r_pc;
    assign bus.inst_valid = w_valid;
    assign bus.inst_word  = w_valid ? r_mem_word[r_rd_ptr] : 32'd0;
    assign bus.inst_pc    = w_valid ? r_mem_pc[r_rd_ptr] : 32'd0;
    assign bus.fifo_count = r_count;

`ifdef DLX_FETCH_STATS_EN
    logic [31:0] r_stat_fetched;
    logic [31:0] r_stat_stall;
    logic        w_stall;

    assign w_stall = (r_state == StHold) || ((r_state == StFetch) && !bus.i_data_valid);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_fetched <= '0;
            r_stat_stall   <= '0;
        end else begin
            if (w_capture) r_stat_fetched <= r_stat_fetched + 32'd1;
            if (w_stall)   r_stat_stall   <= r_stat_stall + 32'd1;
        end
    end

    assign stat_fetched = r_stat_fetched;
    assign stat_stall   = r_stat_stall;
`endif
endmodule
